// File: rtl/seg7_scan32.sv
// seg7_scan32: 8-digit hex display scanner with frame-synchronous snapshot and registered drivers
module seg7_scan32 #(
  parameter int DIV_W = 17,
  parameter bit LZB = 1'b0
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dots,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam logic [15:0][6:0] HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      shadow_data;
  logic [7:0]       shadow_dots;
  logic [31:0]      upper;
  logic             tick;
  logic             dark;
  always_comb begin
    tick  = en & (&cnt);
    upper = shadow_data >> {idx, 2'b00};
    dark  = !en || (LZB && idx != 3'd0 && upper == 32'd0);
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shadow_data <= 32'd0;
      shadow_dots <= 8'd0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= tick && idx == 3'd7;
      if (en) cnt <= cnt + DIV_W'(1);
      if (tick) idx <= idx + 3'd1;
      if (tick && idx == 3'd7) begin
        shadow_data <= data;
        shadow_dots <= dots;
      end
      an  <= dark ? 8'hFF : ~(8'd1 << idx);
      seg <= dark ? 7'h7F : HEX[upper[3:0]];
      dp  <= dark | ~shadow_dots[idx];
    end
  end
endmodule
